// File: rtl/regs_cmd_responder.sv
// regs_cmd_responder: command-interface target with CTRL/STATUS/ERR_CNT/ID register bank
module regs_cmd_responder #(
  parameter int NUM_CTRL = 4,
  parameter logic [31:0] ID_VAL = 32'h5245_4753,
  parameter int ERR_W = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [1:0]              cmd_i,
  input  logic [7:0]              cmd_addr_i,
  input  logic [31:0]             cmd_data_i,
  output logic [31:0]             cmd_data_o,
  output logic                    rsp_vld_o,
  output logic                    err_o,
  input  logic [7:0]              evt_i,
  output logic [32*NUM_CTRL-1:0]  ctrl_o
);
  logic [31:0] ctrl [NUM_CTRL];
  logic [7:0] status;
  logic [ERR_W-1:0] err_cnt;
  logic rd, wr, ill, is_ctrl, is_stat, is_cnt, is_id, rd_ok, wr_ok, err;
  logic [7:0] clr;
  logic [31:0] rdata;
  // command decode, legality and read mux (unmapped addresses read as 0)
  always_comb begin
    rd = cmd_i == 2'b01;
    wr = cmd_i == 2'b10;
    ill = cmd_i == 2'b11;
    is_ctrl = cmd_addr_i[1:0] == 2'b00 && cmd_addr_i[7:2] < 6'(NUM_CTRL);
    is_stat = cmd_addr_i == 8'h10;
    is_cnt = cmd_addr_i == 8'h14;
    is_id = cmd_addr_i == 8'h18;
    rd_ok = rd && (is_ctrl || is_stat || is_cnt || is_id);
    wr_ok = wr && (is_ctrl || is_stat);
    err = ill || (rd && !rd_ok) || (wr && !wr_ok);
    clr = wr_ok && is_stat ? cmd_data_i[7:0] : 8'h00;
    rdata = is_stat ? {24'h0, status} : is_cnt ? 32'(err_cnt) : is_id ? ID_VAL : 32'h0;
    for (int i = 0; i < NUM_CTRL; i++)
      if (is_ctrl && cmd_addr_i[7:2] == 6'(i)) rdata = ctrl[i];
  end
  // register bank, saturating error counter and registered response
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_CTRL; i++) ctrl[i] <= '0;
      status <= '0;
      err_cnt <= '0;
      cmd_data_o <= '0;
      rsp_vld_o <= 1'b0;
      err_o <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CTRL; i++)
        if (wr_ok && is_ctrl && cmd_addr_i[7:2] == 6'(i)) ctrl[i] <= cmd_data_i;
      status <= (status & ~clr) | evt_i;
      if (err && !(&err_cnt)) err_cnt <= err_cnt + ERR_W'(1);
      if (rd) cmd_data_o <= rdata;
      rsp_vld_o <= rd;
      err_o <= err;
    end
  end
  for (genvar n = 0; n < NUM_CTRL; n++) begin : g_ctrl
    assign ctrl_o[32*n +: 32] = ctrl[n];
  end
endmodule
